gpio_in_filter: RTL and testbench
=================================

GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

Interface
REQ-001 Parameter WIDTH, default 32: number of GPIO input bits filtered.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive post-sync mismatch cycles required to accept a new level; legal range 1..65535.
REQ-003 clk  input  1: single clock; all flops rising-edge.
REQ-004 rst_n  input  1: asynchronous active-low reset.
REQ-005 pad_in  input  WIDTH: raw asynchronous pin levels.
REQ-006 gpio_in  output  WIDTH: synchronized, debounced levels; feeds the GPIO IP gpio_in port.
REQ-007 rise_pulse  output  WIDTH: one-cycle pulse per bit on a 0->1 transition of gpio_in.
REQ-008 fall_pulse  output  WIDTH: one-cycle pulse per bit on a 1->0 transition of gpio_in.
REQ-009 evt_clr  input  WIDTH: write-1-to-clear strobe for evt_status bits.
REQ-010 irq_mask  input  WIDTH: per-bit interrupt enable, 1 = enabled.
REQ-011 evt_status  output  WIDTH: sticky edge-event flags.
REQ-012 irq  output  1: level interrupt request.

Function
REQ-013 Each bit SHALL pass through a 2-flop synchronizer: stage1 samples pad_in, stage2 (sync_q) samples stage1.
REQ-014 Each bit SHALL have an independent mismatch counter of width max(1, clog2(DEBOUNCE_CYCLES)).
REQ-015 At each edge, if sync_q[i] == gpio_in[i], counter[i] SHALL clear to 0.
REQ-016 At each edge, if sync_q[i] != gpio_in[i] and counter[i] < DEBOUNCE_CYCLES-1, counter[i] SHALL increment.
REQ-017 At each edge, if sync_q[i] != gpio_in[i] and counter[i] == DEBOUNCE_CYCLES-1, gpio_in[i] SHALL load sync_q[i] and counter[i] SHALL clear to 0.
REQ-018 Latency: a level first captured by stage1 at edge k and held SHALL appear on gpio_in after edge k+1+DEBOUNCE_CYCLES.
REQ-019 A pulse or glitch held for fewer than DEBOUNCE_CYCLES sync_q cycles SHALL leave gpio_in unchanged and SHALL return the counter to 0.
REQ-020 With DEBOUNCE_CYCLES = 1, gpio_in SHALL update on the first mismatch edge, i.e. after edge k+2.
REQ-021 A registered copy gpio_in_d SHALL hold gpio_in delayed by one cycle.
REQ-022 rise_pulse SHALL equal gpio_in & ~gpio_in_d, and fall_pulse SHALL equal ~gpio_in & gpio_in_d; each is high exactly one cycle per transition.
REQ-023 evt_status[i] SHALL set at the edge where rise_pulse[i] or fall_pulse[i] is high.
REQ-024 evt_status[i] SHALL clear at an edge where evt_clr[i] is high and no pulse is present on bit i.
REQ-025 When a set and evt_clr occur on the same bit in the same edge, set SHALL win.
REQ-026 irq SHALL be the combinational OR over all bits of (evt_status & irq_mask).
REQ-027 Bits SHALL be fully independent; simultaneous transitions on multiple bits SHALL each be handled per REQ-013..REQ-025.

Reset
REQ-028 While rst_n is low, all synchronizer flops, counters, gpio_in, gpio_in_d and evt_status SHALL be 0; rise_pulse, fall_pulse and irq SHALL therefore be 0.
REQ-029 Reset assertion SHALL take effect immediately; release SHALL be sampled synchronously on the next clk edge.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count.
REQ-031 A pad held at 1 through reset release SHALL produce gpio_in = 1 and one rise_pulse after the latency given in REQ-018.

Configuration
REQ-032 Macro GPIO_FILT_EDGE_IRQ_EN: when defined, rise_pulse, fall_pulse, evt_status and irq behave per REQ-021..REQ-026.
REQ-033 When GPIO_FILT_EDGE_IRQ_EN is undefined, gpio_in_d and the evt_status flops SHALL not be built.
REQ-034 When GPIO_FILT_EDGE_IRQ_EN is undefined, rise_pulse, fall_pulse, evt_status and irq SHALL be tied to 0.
REQ-035 When GPIO_FILT_EDGE_IRQ_EN is undefined, evt_clr and irq_mask SHALL be ignored, and gpio_in behaviour SHALL be unchanged.

Verification
REQ-036 DEBOUNCE_CYCLES=4: pad_in[0] 0->1 held, stage1 captures at edge k -> gpio_in[0]=1 after edge k+5; rise_pulse[0] high one cycle after edge k+5; evt_status[0]=1 after edge k+6.
REQ-037 DEBOUNCE_CYCLES=4: 3-cycle high glitch on pad_in[3] -> gpio_in[3] stays 0, no pulse, evt_status[3] stays 0.
REQ-038 irq_mask=0x1 with evt_status[0]=1 -> irq=1; evt_clr=0x1 for one cycle -> evt_status[0]=0 and irq=0 next cycle; evt_clr coincident with fall_pulse[0] -> evt_status[0] remains 1.
REQ-039 pad_in=0xFFFF_FFFF at reset release -> gpio_in=0xFFFF_FFFF after latency, rise_pulse=0xFFFF_FFFF for one cycle; rst_n pulsed low two cycles into a debounce -> all outputs 0 and the count restarts.
REQ-040 Build without GPIO_FILT_EDGE_IRQ_EN: repeat REQ-036 stimulus -> gpio_in timing identical; rise_pulse, evt_status and irq constantly 0.

Source files
------------

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-bit 2-flop synchronizer and mismatch-count debouncer
// feeding gpio_in. The optional edge-pulse / sticky-event / interrupt logic is
// built only when the macro GPIO_FILT_EDGE_IRQ_EN is defined. Otherwise those
// outputs are tied to 0 and evt_clr / irq_mask are ignored.
module gpio_in_filter #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 16   // legal range 1..65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    input  logic [WIDTH-1:0] evt_clr,
    input  logic [WIDTH-1:0] irq_mask,
    output logic [WIDTH-1:0] evt_status,
    output logic             irq
);

    // DEBOUNCE_CYCLES = 1 would give a zero-width counter, so keep at least one bit.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] sync_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];

    // Two-flop synchronizer for the asynchronous pad levels.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its source; blocking here would collapse the stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_q <= '0;
            sync_q   <= '0;
        end else begin
            stage1_q <= pad_in;
            sync_q   <= stage1_q;
        end
    end

    // Per-bit debounce: count consecutive mismatches, accept the new level on the last one.
    // NOTE: the counter array is control state, not data storage, so every
    // entry is reset; a partial count must never survive a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_in <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_q[i] == gpio_in[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    gpio_in[i] <= sync_q[i];
                    cnt_q[i]   <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

`ifdef GPIO_FILT_EDGE_IRQ_EN
    logic [WIDTH-1:0] gpio_in_d;

    // One-cycle delayed copy of the filtered level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_in_d <= '0;
        end else begin
            gpio_in_d <= gpio_in;
        end
    end

    assign rise_pulse = gpio_in & ~gpio_in_d;
    assign fall_pulse = ~gpio_in & gpio_in_d;

    // Sticky event flags: a pulse sets, evt_clr clears, and a set beats a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_status <= '0;
        end else begin
            evt_status <= rise_pulse | fall_pulse | (evt_status & ~evt_clr);
        end
    end

    assign irq = |(evt_status & irq_mask);
`else
    // Edge/interrupt logic not built: outputs are constant and the control inputs are unused.
    logic unused_edge_inputs;

    assign unused_edge_inputs = ^{evt_clr, irq_mask};
    assign rise_pulse         = '0;
    assign fall_pulse         = '0;
    assign evt_status         = '0;
    assign irq                = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// Self-checking bench for gpio_in_filter: directed vector table for the
// debounce/event/interrupt sequence, hand sequences for glitch, reset and
// DEBOUNCE_CYCLES=1 corners, then random pad activity against a reference model.
module tb_gpio_in_filter;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int W1 = 4;

`ifdef GPIO_FILT_EDGE_IRQ_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  pad = '0, clr = '0, mask = '0;
    logic [W-1:0]  gpio, rise, fall, evt;
    logic          irq;

    logic [W1-1:0] pad1 = '0;
    logic [W1-1:0] gpio1, rise1, fall1, evt1;
    logic          irq1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gpio_in_filter #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .pad_in(pad), .gpio_in(gpio),
        .rise_pulse(rise), .fall_pulse(fall), .evt_clr(clr),
        .irq_mask(mask), .evt_status(evt), .irq(irq)
    );

    gpio_in_filter #(.WIDTH(W1), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pad_in(pad1), .gpio_in(gpio1),
        .rise_pulse(rise1), .fall_pulse(fall1), .evt_clr('0),
        .irq_mask('0), .evt_status(evt1), .irq(irq1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] gate(input logic [W-1:0] x);
        return EDGE_EN ? x : '0;
    endfunction

    // ---------------- reference model ----------------
    // A bit accepts a new level at edge n when the synchronized value seen at
    // each of the last D edges differed from the current level and all of those
    // edges came after the bit's previous change (or after reset).
    logic [W-1:0] pad_hist[$];
    int           n_edge;
    int           last_chg[W];
    logic [W-1:0] gm, gm_d, em;

    function automatic void model_reset();
        pad_hist.delete();
        n_edge = 0;
        gm     = '0;
        gm_d   = '0;
        em     = '0;
        for (int i = 0; i < W; i++) last_chg[i] = -1;
    endfunction

    // Synchronized value presented to the filter at edge e: pad sampled two edges earlier.
    function automatic logic sync_seen(input int e, input int i);
        logic [W-1:0] v;
        if (e < 2) return 1'b0;
        v = pad_hist[e-2];
        return v[i];
    endfunction

    function automatic void model_edge(input logic [W-1:0] p, input logic [W-1:0] c);
        logic [W-1:0] g_new;
        logic [W-1:0] pulse;
        bit           acc;
        pad_hist.push_back(p);
        g_new = gm;
        pulse = (gm & ~gm_d) | (~gm & gm_d);
        for (int i = 0; i < W; i++) begin
            acc = 1'b1;
            for (int j = 0; j < D; j++) begin
                if ((n_edge - j) <= last_chg[i] || sync_seen(n_edge - j, i) == gm[i]) acc = 1'b0;
            end
            if (acc) begin
                g_new[i]    = ~gm[i];
                last_chg[i] = n_edge;
            end
        end
        em     = pulse | (em & ~c);
        gm_d   = gm;
        gm     = g_new;
        n_edge = n_edge + 1;
    endfunction

    // Advance one clock edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        model_edge(pad, clr);
        #1;
    endtask

    // Assert reset mid-cycle, verify the immediate clear, release just after the next edge.
    task automatic do_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        check({tag, "_gpio"}, gpio, 0);
        check({tag, "_rise"}, rise, 0);
        check({tag, "_fall"}, fall, 0);
        check({tag, "_evt"},  evt,  0);
        check({tag, "_irq"},  irq,  0);
        check({tag, "_gpio1"}, gpio1, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_model();
        check("rnd_gpio", gpio, gm);
        check("rnd_rise", rise, gate(gm & ~gm_d));
        check("rnd_fall", fall, gate(~gm & gm_d));
        check("rnd_evt",  evt,  gate(em));
        check("rnd_irq",  irq,  EDGE_EN & (|(em & mask)));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [W-1:0] pad;
        logic [W-1:0] clr;
        logic [W-1:0] mask;
        logic         g, r, f, e, q;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Bit 0, D=4: rise accepted after edge 5, event + irq, clear, fall with coincident clear.
        for (int r = 0; r < 17; r++) tbl[r] = '{32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int r = 0; r < 8; r++) tbl[r].pad = 32'h1;
        for (int r = 5; r < 13; r++) tbl[r].g = 1'b1;
        tbl[5].r  = 1'b1;
        tbl[6].e  = 1'b1; tbl[6].q = 1'b1;
        tbl[7].clr = 32'h1;
        tbl[13].f = 1'b1;
        tbl[14].clr = 32'h1;
        for (int r = 14; r < 17; r++) tbl[r].e = 1'b1;
        tbl[14].q = 1'b1; tbl[15].q = 1'b1;
        tbl[16].mask = 32'h0;

        do_reset("rst0");
        for (int r = 0; r < 17; r++) begin
            pad = tbl[r].pad; clr = tbl[r].clr; mask = tbl[r].mask;
            step();
            check($sformatf("tbl%0d_gpio", r), gpio, {31'b0, tbl[r].g});
            check($sformatf("tbl%0d_rise", r), rise, gate({31'b0, tbl[r].r}));
            check($sformatf("tbl%0d_fall", r), fall, gate({31'b0, tbl[r].f}));
            check($sformatf("tbl%0d_evt",  r), evt,  gate({31'b0, tbl[r].e}));
            check($sformatf("tbl%0d_irq",  r), irq,  EDGE_EN & tbl[r].q);
        end
        clr = '0;

        // Bit 3: 3-cycle glitch rejected, then a 4-cycle pulse accepted exactly at the boundary.
        for (int c = 0; c < 10; c++) begin
            pad = (c < 3) ? 32'h8 : 32'h0;
            step();
            check("glitch_gpio3", gpio[3], 0);
            check("glitch_rise3", rise[3], 0);
            check("glitch_evt3",  evt[3],  0);
        end
        for (int c = 0; c < 12; c++) begin
            pad = (c < 4) ? 32'h8 : 32'h0;
            step();
            check($sformatf("pulse4_gpio3_c%0d", c), gpio[3], (c >= 5 && c < 9) ? 1 : 0);
        end

        // Pads all high through release; a reset two cycles into the debounce restarts the count.
        pad = '1;
        pad1 = 4'hA;
        do_reset("rst1");
        for (int c = 0; c < 3; c++) step();
        check("dbc1_edge1", gpio1, 4'hA);
        do_reset("rst2");
        for (int c = 0; c < 7; c++) begin
            step();
            if (c == 0) check("dbc1_after_k", gpio1, 0);
            if (c == 1) check("dbc1_after_k1", gpio1, 0);
            if (c == 2) check("dbc1_after_k2", gpio1, 4'hA);
            if (c == 4) check("all1_edge4_gpio", gpio, 0);
            if (c == 5) begin
                check("all1_edge5_gpio", gpio, 32'hFFFF_FFFF);
                check("all1_edge5_rise", rise, gate(32'hFFFF_FFFF));
            end
            if (c == 6) begin
                check("all1_edge6_rise", rise, 0);
                check("all1_edge6_evt",  evt,  gate(32'hFFFF_FFFF));
            end
        end

        // Random pad activity against the reference model, with one mid-run reset.
        pad  = $urandom;
        mask = $urandom;
        do_reset("rst3");
        for (int c = 0; c < 800; c++) begin
            if (c == 400) do_reset("rst4");
            pad = pad ^ ($urandom & $urandom & $urandom);
            clr = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 15) == 0) mask = $urandom;
            step();
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
